// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered WIDTH-bit ripple-carry adder built from 1-bit full-adder cells
// Carry chain is combinational; sum, carry out, carry vector and valid are registered.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] carries
);
  // chain[i] is the carry into bit i; chain[WIDTH] is the final carry out
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum;

  assign chain[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[gi]),
      .b  (b[gi]),
      .c  (chain[gi]),
      .s  (sum[gi]),
      .co (chain[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      carries   <= '0;
    end else begin
      out_valid <= in_valid;
      // Results hold while idle so X on idle inputs never reaches the outputs
      if (in_valid) begin
        s       <= sum;
        cout    <= chain[WIDTH];
        carries <= chain[WIDTH:1];
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH 1, 8 and 16
// Arithmetic reference model plus hand-computed directed expectations.

module tb_full_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        v1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic        ov1, s1, co1, cv1;
  logic        v8 = 0, c8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        ov8, co8;
  logic [7:0]  s8, cv8;
  logic        v16 = 0, c16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        ov16, co16;
  logic [15:0] s16, cv16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .s(s1), .cout(co1), .carries(cv1));
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .s(s8), .cout(co8), .carries(cv8));
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .out_valid(ov16), .s(s16), .cout(co16), .carries(cv16));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Carry out of bit i is bit i+1 of the sum of the low i+1 bits of the operands
  function automatic longint unsigned carry_vec(input int w, input longint unsigned a,
                                                input longint unsigned b, input bit cin);
    longint unsigned r = 0;
    for (int i = 0; i < w; i++) begin
      longint unsigned m = (64'd1 << (i + 1)) - 1;
      longint unsigned t = (a & m) + (b & m) + 64'(cin);
      r |= ((t >> (i + 1)) & 64'd1) << i;
    end
    return r;
  endfunction

  function automatic longint unsigned total(input longint unsigned a, input longint unsigned b,
                                            input bit cin);
    return a + b + 64'(cin);
  endfunction

  logic        m_v1, m_s1, m_co1, m_cv1;
  logic        m_v8, m_co8;
  logic [7:0]  m_s8, m_cv8;
  logic        m_v16, m_co16;
  logic [15:0] m_s16, m_cv16;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v1 <= 0; m_s1 <= 0; m_co1 <= 0; m_cv1 <= 0;
      m_v8 <= 0; m_s8 <= 0; m_co8 <= 0; m_cv8 <= 0;
      m_v16 <= 0; m_s16 <= 0; m_co16 <= 0; m_cv16 <= 0;
    end else begin
      m_v1 <= v1;
      m_v8 <= v8;
      m_v16 <= v16;
      if (v1) begin
        m_s1  <= total(64'(a1), 64'(b1), c1) % 2;
        m_co1 <= (total(64'(a1), 64'(b1), c1) >> 1) & 1;
        m_cv1 <= 1'(carry_vec(1, 64'(a1), 64'(b1), c1));
      end
      if (v8) begin
        m_s8  <= 8'(total(64'(a8), 64'(b8), c8) % 256);
        m_co8 <= (total(64'(a8), 64'(b8), c8) >> 8) & 1;
        m_cv8 <= 8'(carry_vec(8, 64'(a8), 64'(b8), c8));
      end
      if (v16) begin
        m_s16  <= 16'(total(64'(a16), 64'(b16), c16) % 65536);
        m_co16 <= (total(64'(a16), 64'(b16), c16) >> 16) & 1;
        m_cv16 <= 16'(carry_vec(16, 64'(a16), 64'(b16), c16));
      end
    end
  end

  always @(negedge clk) begin
    chk("w1_valid", 64'(ov1), 64'(m_v1));
    chk("w1_sum", {63'd0, co1, s1}, {63'd0, m_co1, m_s1});
    chk("w1_carries", 64'(cv1), 64'(m_cv1));
    chk("w8_valid", 64'(ov8), 64'(m_v8));
    chk("w8_sum", {55'd0, co8, s8}, {55'd0, m_co8, m_s8});
    chk("w8_carries", 64'(cv8), 64'(m_cv8));
    chk("w16_valid", 64'(ov16), 64'(m_v16));
    chk("w16_sum", {47'd0, co16, s16}, {47'd0, m_co16, m_s16});
    chk("w16_carries", 64'(cv16), 64'(m_cv16));
  end

  logic [7:0] tt_s = 8'b1001_0110;
  logic [7:0] tt_c = 8'b1110_1000;
  logic [7:0] ba [4];
  logic [7:0] bb [4];
  logic       bc [4];

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_s8", 64'(s8), 64'h0);
    chk("reset_valid8", 64'(ov8), 64'h0);
    rst_n = 1'b1;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1; a1 = i[2]; b1 = i[1]; c1 = i[0];
      @(posedge clk); #1;
      chk($sformatf("tt_s_%0d", i), 64'(s1), 64'(tt_s[i]));
      chk($sformatf("tt_cout_%0d", i), 64'(co1), 64'(tt_c[i]));
      chk($sformatf("tt_valid_%0d", i), 64'(ov1), 64'h1);
    end
    @(negedge clk); v1 = 0; a1 = 'x; b1 = 'x; c1 = 'x;

    // Full ripple through all eight cells
    v8 = 1; a8 = 8'hFF; b8 = 8'h00; c8 = 1;
    @(posedge clk); #1;
    chk("ripple_s", 64'(s8), 64'h00);
    chk("ripple_cout", 64'(co8), 64'h1);
    chk("ripple_carries", 64'(cv8), 64'hFF);

    @(negedge clk); a8 = 8'h0F; b8 = 8'h01; c8 = 0;
    @(posedge clk); #1;
    chk("low_nibble_s", 64'(s8), 64'h10);
    chk("low_nibble_cout", 64'(co8), 64'h0);
    chk("low_nibble_carries", 64'(cv8), 64'h0F);
    @(negedge clk); v8 = 0; a8 = 'x; b8 = 'x; c8 = 'x;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_s", 64'(s8), 64'h10);
      chk("hold_valid", 64'(ov8), 64'h0);
    end

    // Back-to-back valid cycles
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); v8 = 1; a8 = ba[i]; b8 = bb[i]; c8 = bc[i];
      @(posedge clk); #1;
      chk("b2b_valid", 64'(ov8), 64'h1);
      chk("b2b_sum", {55'd0, co8, s8}, 64'(ba[i]) + 64'(bb[i]) + 64'(bc[i]));
    end

    // Asynchronous reset while clk is high, no edge in between
    @(negedge clk); a8 = 8'hFF; b8 = 8'h01; c8 = 0;
    @(posedge clk); #1;
    chk("pre_reset_cout", 64'(co8), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_s", 64'(s8), 64'h0);
    chk("async_cout", 64'(co8), 64'h0);
    chk("async_carries", 64'(cv8), 64'h0);
    chk("async_valid", 64'(ov8), 64'h0);
    @(negedge clk); v8 = 0; rst_n = 1'b1;

    // Random vectors on all widths, X on idle inputs
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      v1 = ($urandom_range(7) != 0);
      v8 = ($urandom_range(7) != 0);
      v16 = ($urandom_range(7) != 0);
      if (v1) begin a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); end
      else begin a1 = 'x; b1 = 'x; c1 = 'x; end
      if (v8) begin a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); end
      else begin a8 = 'x; b8 = 'x; c8 = 'x; end
      if (v16) begin a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); end
      else begin a16 = 'x; b16 = 'x; c16 = 'x; end
    end
    @(negedge clk); v1 = 0; v8 = 0; v16 = 0;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
